// File: rtl/i2c_xfer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_xfer_sequencer
// Purpose  : Runs one whole I2C transaction on top of a byte-level master
//            engine. It sends the address byte with START, then the data bytes,
//            and the last data byte carries STOP. If the slave NACKs, it
//            finishes the transfer with a dummy STOP byte.
// Ports    : cmd_*     - command in (address, R/W, length), valid/ready
//            wdata_*   - write byte stream in, valid/ready
//            rdata_*   - read byte stream out, valid/ready
//            rsp_*     - per-transaction status/count out, valid/ready
//            busy      - high whenever not idle
//            eng_*     - byte engine request/response
// Revision : 1.0 - initial release
// ============================================================================
module i2c_xfer_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rw,
    input  logic [6:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [7:0]       wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [7:0]       rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic [LEN_W-1:0] rsp_count,
    output logic             busy,
    output logic             eng_start,
    input  logic             eng_idle,
    input  logic             eng_done,
    output logic [1:0]       eng_mode,
    output logic             eng_dir,
    output logic [7:0]       eng_tx_byte,
    input  logic [7:0]       eng_rx_byte,
    input  logic             eng_resp_err
);

    localparam logic [3:0] c_S_IDLE       = 4'd0;
    localparam logic [3:0] c_S_ADDR       = 4'd1;
    localparam logic [3:0] c_S_ADDR_WAIT  = 4'd2;
    localparam logic [3:0] c_S_DATA_FETCH = 4'd3;
    localparam logic [3:0] c_S_DATA_ISSUE = 4'd4;
    localparam logic [3:0] c_S_DATA_WAIT  = 4'd5;
    localparam logic [3:0] c_S_RD_HOLD    = 4'd6;
    localparam logic [3:0] c_S_ABORT      = 4'd7;
    localparam logic [3:0] c_S_ABORT_WAIT = 4'd8;
    localparam logic [3:0] c_S_RESP       = 4'd9;

    localparam logic [1:0] c_MODE_START  = 2'b00;
    localparam logic [1:0] c_MODE_STOP   = 2'b01;
    localparam logic [1:0] c_MODE_NORMAL = 2'b10;

    localparam logic [1:0] c_ST_OK        = 2'b00;
    localparam logic [1:0] c_ST_ADDR_NACK = 2'b01;
    localparam logic [1:0] c_ST_DATA_NACK = 2'b10;
    localparam logic [1:0] c_ST_BAD_LEN   = 2'b11;

    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             r_rw;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_count;
    logic [1:0]       r_status;
    logic             r_nack;
    logic [7:0]       r_tx;
    logic [7:0]       r_rdata;
    logic             w_last;
    logic             w_nack_now;

    // w_last looks at the count before it is decremented. In RD_HOLD the
    // count has already been decremented, so that state checks for zero.
    assign w_last     = (r_remaining == c_LEN_ONE);
    // A NACK pulse can arrive in the same cycle as eng_done.
    assign w_nack_now = r_nack | eng_resp_err;

    assign busy        = (r_state != c_S_IDLE);
    assign eng_tx_byte = r_tx;
    assign rdata       = r_rdata;
    assign rsp_status  = r_status;
    assign rsp_count   = r_count;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (cmd_valid) begin
                    w_next = (cmd_len == '0) ? c_S_RESP : c_S_ADDR;
                end
            end
            c_S_ADDR: begin
                if (eng_idle) w_next = c_S_ADDR_WAIT;
            end
            c_S_ADDR_WAIT: begin
                if (eng_done) begin
                    if (w_nack_now)  w_next = c_S_ABORT;
                    else if (r_rw)   w_next = c_S_DATA_ISSUE;
                    else             w_next = c_S_DATA_FETCH;
                end
            end
            c_S_DATA_FETCH: begin
                if (wdata_valid) w_next = c_S_DATA_ISSUE;
            end
            c_S_DATA_ISSUE: begin
                if (eng_idle) w_next = c_S_DATA_WAIT;
            end
            c_S_DATA_WAIT: begin
                if (eng_done) begin
                    if (r_rw)            w_next = c_S_RD_HOLD;
                    else if (w_last)     w_next = c_S_RESP;   // STOP already on the bus
                    else if (w_nack_now) w_next = c_S_ABORT;
                    else                 w_next = c_S_DATA_FETCH;
                end
            end
            c_S_RD_HOLD: begin
                if (rdata_ready) begin
                    w_next = (r_remaining == '0) ? c_S_RESP : c_S_DATA_ISSUE;
                end
            end
            c_S_ABORT: begin
                if (eng_idle) w_next = c_S_ABORT_WAIT;
            end
            c_S_ABORT_WAIT: begin
                if (eng_done) w_next = c_S_RESP;
            end
            c_S_RESP: begin
                if (rsp_ready) w_next = c_S_IDLE;
            end
            default: w_next = c_S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rsp_valid   = 1'b0;
        eng_start   = 1'b0;
        eng_mode    = c_MODE_NORMAL;
        eng_dir     = 1'b0;
        case (r_state)
            c_S_IDLE:       cmd_ready   = 1'b1;
            c_S_ADDR: begin
                eng_start = 1'b1;
                eng_mode  = c_MODE_START;
            end
            c_S_DATA_FETCH: wdata_ready = 1'b1;
            c_S_DATA_ISSUE: begin
                eng_start = 1'b1;
                eng_dir   = r_rw;
                eng_mode  = w_last ? c_MODE_STOP : c_MODE_NORMAL;
            end
            c_S_RD_HOLD:    rdata_valid = 1'b1;
            c_S_ABORT: begin
                // Dummy receive: the master NACKs it and then sends STOP.
                eng_start = 1'b1;
                eng_mode  = c_MODE_STOP;
                eng_dir   = 1'b1;
            end
            c_S_RESP:       rsp_valid   = 1'b1;
            default: ;
        endcase
    end

    // Transaction datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rw        <= 1'b0;
            r_remaining <= '0;
            r_count     <= '0;
            r_status    <= c_ST_OK;
            r_nack      <= 1'b0;
            r_tx        <= 8'h00;
            r_rdata     <= 8'h00;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (cmd_valid) begin
                        r_rw        <= cmd_rw;
                        r_remaining <= cmd_len;
                        r_count     <= '0;
                        r_status    <= (cmd_len == '0) ? c_ST_BAD_LEN : c_ST_OK;
                        r_nack      <= 1'b0;
                        r_tx        <= {cmd_addr, cmd_rw};
                    end
                end
                c_S_ADDR_WAIT: begin
                    if (eng_resp_err) r_nack <= 1'b1;
                    if (eng_done) begin
                        r_nack <= 1'b0;
                        if (w_nack_now) begin
                            r_status <= c_ST_ADDR_NACK;
                            r_tx     <= 8'hFF;
                        end
                    end
                end
                c_S_DATA_FETCH: begin
                    if (wdata_valid) r_tx <= wdata;
                end
                c_S_DATA_WAIT: begin
                    // A NACK on a receive byte comes from the master, so it is ignored.
                    if (!r_rw && eng_resp_err) r_nack <= 1'b1;
                    if (eng_done) begin
                        r_nack <= 1'b0;
                        if (r_rw) begin
                            r_rdata     <= eng_rx_byte;
                            r_count     <= r_count + c_LEN_ONE;
                            r_remaining <= r_remaining - c_LEN_ONE;
                        end else if (w_nack_now) begin
                            r_status <= c_ST_DATA_NACK;
                            if (!w_last) r_tx <= 8'hFF;
                        end else begin
                            r_count     <= r_count + c_LEN_ONE;
                            r_remaining <= r_remaining - c_LEN_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_xfer_sequencer
// Purpose  : Self-checking bench for i2c_xfer_sequencer. It uses a behavioural
//            byte-engine model, a table of transactions and a few
//            hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_xfer_sequencer;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wdata_valid, wdata_ready;
    logic [7:0]       wdata;
    logic             rdata_valid, rdata_ready;
    logic [7:0]       rdata;
    logic             rsp_valid, rsp_ready;
    logic [1:0]       rsp_status;
    logic [LEN_W-1:0] rsp_count;
    logic             busy, eng_start, eng_idle, eng_done, eng_dir, eng_resp_err;
    logic [1:0]       eng_mode;
    logic [7:0]       eng_tx_byte, eng_rx_byte;

    always #5 clk = ~clk;

    i2c_xfer_sequencer #(.LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_count(rsp_count), .busy(busy),
        .eng_start(eng_start), .eng_idle(eng_idle), .eng_done(eng_done),
        .eng_mode(eng_mode), .eng_dir(eng_dir), .eng_tx_byte(eng_tx_byte),
        .eng_rx_byte(eng_rx_byte), .eng_resp_err(eng_resp_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- byte engine model ----------------
    // Each accepted byte is logged as {mode, dir, tx}. The driver sets the
    // transfer-relative receive data and the absolute log index to NACK.
    int               log_n = 0;
    logic [10:0]      log_byte [256];
    int               base = 0;
    int               nack_abs = -1000;
    bit               nack_with_done = 1'b0;
    logic [3:0][7:0]  rx_tab = '0;

    initial begin
        int  idx;
        int  pos;
        bit  is_rx;
        eng_idle     = 1'b1;
        eng_done     = 1'b0;
        eng_resp_err = 1'b0;
        eng_rx_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && eng_start === 1'b1 && eng_idle) begin
                idx = log_n;
                if (idx < 256) log_byte[idx] = {eng_mode, eng_dir, eng_tx_byte};
                log_n++;
                is_rx = eng_dir;
                pos = idx - base;
                step();
                eng_idle = 1'b0;
                step();
                step();
                if (idx == nack_abs && !nack_with_done) eng_resp_err = 1'b1;
                step();
                eng_resp_err = 1'b0;
                eng_done     = 1'b1;
                eng_idle     = 1'b1;
                if (is_rx) eng_rx_byte = (pos >= 1 && pos <= 4) ? rx_tab[pos-1] : 8'hEE;
                if (idx == nack_abs && nack_with_done) eng_resp_err = 1'b1;
                step();
                eng_done     = 1'b0;
                eng_resp_err = 1'b0;
            end
        end
    end

    // ---------------- transaction table ----------------
    typedef struct packed {
        logic             rw;
        logic [6:0]       addr;
        logic [7:0]       len;
        logic [3:0][7:0]  wd;
        int               nack_at;     // issued-byte index to NACK (0 = address), -1 none
        logic             nack_wd;     // NACK arrives together with eng_done
        logic [3:0][7:0]  rx;
        int               n_bytes;
        logic [5:0][11:0] eb;          // {check_tx, mode, dir, tx}
        int               n_rd;
        logic [3:0][7:0]  exp_rd;
        logic [1:0]       exp_st;
        logic [7:0]       exp_cnt;
        int               exp_wtake;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vec [NVEC];

    function automatic logic [11:0] eb(input logic chk, input logic [1:0] m,
                                       input logic d, input logic [7:0] t);
        return {chk, m, d, t};
    endfunction

    task automatic fill_vectors();
        for (int i = 0; i < NVEC; i++) vec[i] = '0;
        // 0: write 0x50 len 2, all ACK
        vec[0].rw = 0; vec[0].addr = 7'h50; vec[0].len = 2; vec[0].nack_at = -1;
        vec[0].wd = {8'h00, 8'h00, 8'h3C, 8'hA5};
        vec[0].n_bytes = 3;
        vec[0].eb[0] = eb(1, 2'b00, 0, 8'hA0);
        vec[0].eb[1] = eb(1, 2'b10, 0, 8'hA5);
        vec[0].eb[2] = eb(1, 2'b01, 0, 8'h3C);
        vec[0].exp_st = 2'b00; vec[0].exp_cnt = 2; vec[0].exp_wtake = 2;
        // 1: read 0x50 len 3
        vec[1].rw = 1; vec[1].addr = 7'h50; vec[1].len = 3; vec[1].nack_at = -1;
        vec[1].rx = {8'h00, 8'h33, 8'h22, 8'h11};
        vec[1].n_bytes = 4;
        vec[1].eb[0] = eb(1, 2'b00, 0, 8'hA1);
        vec[1].eb[1] = eb(0, 2'b10, 1, 8'h00);
        vec[1].eb[2] = eb(0, 2'b10, 1, 8'h00);
        vec[1].eb[3] = eb(0, 2'b01, 1, 8'h00);
        vec[1].n_rd = 3; vec[1].exp_rd = {8'h00, 8'h33, 8'h22, 8'h11};
        vec[1].exp_st = 2'b00; vec[1].exp_cnt = 3;
        // 2: write 0x2A len 3, address NACK (early pulse)
        vec[2].rw = 0; vec[2].addr = 7'h2A; vec[2].len = 3; vec[2].nack_at = 0;
        vec[2].wd = {8'h00, 8'h33, 8'h22, 8'h11};
        vec[2].n_bytes = 2;
        vec[2].eb[0] = eb(1, 2'b00, 0, 8'h54);
        vec[2].eb[1] = eb(1, 2'b01, 1, 8'hFF);
        vec[2].exp_st = 2'b01; vec[2].exp_cnt = 0; vec[2].exp_wtake = 0;
        // 3: write 0x13 len 4, NACK on 2nd data byte (with done)
        vec[3].rw = 0; vec[3].addr = 7'h13; vec[3].len = 4; vec[3].nack_at = 2; vec[3].nack_wd = 1;
        vec[3].wd = {8'h04, 8'h03, 8'h02, 8'h01};
        vec[3].n_bytes = 4;
        vec[3].eb[0] = eb(1, 2'b00, 0, 8'h26);
        vec[3].eb[1] = eb(1, 2'b10, 0, 8'h01);
        vec[3].eb[2] = eb(1, 2'b10, 0, 8'h02);
        vec[3].eb[3] = eb(1, 2'b01, 1, 8'hFF);
        vec[3].exp_st = 2'b10; vec[3].exp_cnt = 1; vec[3].exp_wtake = 2;
        // 4: write 0x13 len 4, NACK on last byte: no abort
        vec[4].rw = 0; vec[4].addr = 7'h13; vec[4].len = 4; vec[4].nack_at = 4;
        vec[4].wd = {8'h04, 8'h03, 8'h02, 8'h01};
        vec[4].n_bytes = 5;
        vec[4].eb[0] = eb(1, 2'b00, 0, 8'h26);
        vec[4].eb[1] = eb(1, 2'b10, 0, 8'h01);
        vec[4].eb[2] = eb(1, 2'b10, 0, 8'h02);
        vec[4].eb[3] = eb(1, 2'b10, 0, 8'h03);
        vec[4].eb[4] = eb(1, 2'b01, 0, 8'h04);
        vec[4].exp_st = 2'b10; vec[4].exp_cnt = 3; vec[4].exp_wtake = 4;
        // 5: read 0x7F len 1: the only data byte carries STOP
        vec[5].rw = 1; vec[5].addr = 7'h7F; vec[5].len = 1; vec[5].nack_at = -1;
        vec[5].rx = {8'h00, 8'h00, 8'h00, 8'h9C};
        vec[5].n_bytes = 2;
        vec[5].eb[0] = eb(1, 2'b00, 0, 8'hFF);
        vec[5].eb[1] = eb(0, 2'b01, 1, 8'h00);
        vec[5].n_rd = 1; vec[5].exp_rd = {8'h00, 8'h00, 8'h00, 8'h9C};
        vec[5].exp_st = 2'b00; vec[5].exp_cnt = 1;
        // 6: read 0x31 len 2, address NACK (with done)
        vec[6].rw = 1; vec[6].addr = 7'h31; vec[6].len = 2; vec[6].nack_at = 0; vec[6].nack_wd = 1;
        vec[6].n_bytes = 2;
        vec[6].eb[0] = eb(1, 2'b00, 0, 8'h63);
        vec[6].eb[1] = eb(1, 2'b01, 1, 8'hFF);
        vec[6].exp_st = 2'b01; vec[6].exp_cnt = 0;
        // 7: read 0x50 len 2, resp_err on a receive byte is ignored
        vec[7].rw = 1; vec[7].addr = 7'h50; vec[7].len = 2; vec[7].nack_at = 1;
        vec[7].rx = {8'h00, 8'h00, 8'h55, 8'h44};
        vec[7].n_bytes = 3;
        vec[7].eb[0] = eb(1, 2'b00, 0, 8'hA1);
        vec[7].eb[1] = eb(0, 2'b10, 1, 8'h00);
        vec[7].eb[2] = eb(0, 2'b01, 1, 8'h00);
        vec[7].n_rd = 2; vec[7].exp_rd = {8'h00, 8'h00, 8'h55, 8'h44};
        vec[7].exp_st = 2'b00; vec[7].exp_cnt = 2;
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
    task automatic run_vec(input int vi);
        vec_t       v;
        int         wi, ri, wtake, nlog;
        bit         done, tc, tw, tr, ts;
        logic [1:0] st;
        logic [7:0] cnt;
        logic [7:0] rd [4];
        string      nm;
        v = vec[vi];
        base = log_n;
        nack_abs = (v.nack_at >= 0) ? log_n + v.nack_at : -1000;
        nack_with_done = v.nack_wd;
        rx_tab = v.rx;
        cmd_valid = 1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_len = v.len;
        wdata_valid = !v.rw; wdata = v.wd[0]; rdata_ready = 1; rsp_ready = 1;
        wi = 0; ri = 0; wtake = 0; done = 0; st = 0; cnt = 0;
        for (int k = 0; k < 4; k++) rd[k] = 8'h00;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(negedge clk);
            tc = cmd_valid && cmd_ready;
            tw = wdata_valid && wdata_ready;
            tr = rdata_valid && rdata_ready;
            ts = rsp_valid && rsp_ready;
            if (tr) begin
                if (ri < 4) rd[ri] = rdata;
                ri++;
            end
            if (ts) begin
                st = rsp_status; cnt = rsp_count; done = 1;
            end
            step();
            if (tc) cmd_valid = 0;
            if (tw) begin
                wtake++; wi++;
                if (wi < 4) wdata = v.wd[wi];
                else wdata_valid = 0;
            end
        end
        wdata_valid = 0;
        nm = $sformatf("v%0d", vi);
        check({nm, "_rsp_seen"}, 64'(done), 64'd1);
        nlog = log_n - base;
        check({nm, "_nbytes"}, 64'(nlog), 64'(v.n_bytes));
        for (int k = 0; k < v.n_bytes && k < nlog; k++) begin
            if (v.eb[k][11])
                check($sformatf("%s_byte%0d", nm, k), 64'(log_byte[base+k]), 64'(v.eb[k][10:0]));
            else
                check($sformatf("%s_byte%0d_md", nm, k), 64'(log_byte[base+k][10:8]), 64'(v.eb[k][10:8]));
        end
        check({nm, "_status"}, 64'(st), 64'(v.exp_st));
        check({nm, "_count"}, 64'(cnt), 64'(v.exp_cnt));
        check({nm, "_wtake"}, 64'(wtake), 64'(v.exp_wtake));
        check({nm, "_nrd"}, 64'(ri), 64'(v.n_rd));
        for (int k = 0; k < v.n_rd && k < 4; k++)
            check($sformatf("%s_rd%0d", nm, k), 64'(rd[k]), 64'(v.exp_rd[k]));
    endtask

    function automatic logic [34:0] out_bundle();
        return {cmd_ready, wdata_ready, rdata_valid, rsp_valid, busy, eng_start,
                eng_mode, eng_dir, eng_tx_byte, rdata, rsp_status, rsp_count};
    endfunction

    localparam logic [34:0] c_RESET_OUTS = {1'b1, 5'b00000, 2'b10, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00};

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int bad;
        resetn = 0; cmd_valid = 0; cmd_rw = 0; cmd_addr = 0; cmd_len = 0;
        wdata_valid = 0; wdata = 0; rdata_ready = 0; rsp_ready = 0;
        fill_vectors();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(out_bundle()), 64'(c_RESET_OUTS));
        resetn = 1;
        step();

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // ---- read with rdata back-pressure ----
        base = log_n; nack_abs = -1000; nack_with_done = 0;
        rx_tab = {8'h00, 8'h00, 8'hBB, 8'hAA};
        cmd_valid = 1; cmd_rw = 1; cmd_addr = 7'h50; cmd_len = 2;
        rdata_ready = 0; rsp_ready = 0; wdata_valid = 0;
        step();
        cmd_valid = 0;
        check("bp_addr_start_latency", 64'({eng_start, eng_mode, eng_dir, eng_tx_byte}),
              64'({1'b1, 2'b00, 1'b0, 8'hA1}));
        cyc = 0;
        while (rdata_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        check("bp_rd0_valid", 64'(rdata_valid), 64'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (eng_start !== 1'b0 || rdata_valid !== 1'b1 || rdata !== 8'hAA) bad++;
        end
        check("bp_hold_stable", 64'(bad), 64'd0);
        check("bp_rd0_data", 64'(rdata), 64'hAA);
        step();
        rdata_ready = 1;
        step();
        rdata_ready = 0;
        check("bp_reissue_latency", 64'({eng_start, eng_mode, eng_dir}), 64'({1'b1, 2'b01, 1'b1}));
        cyc = 0;
        while (rdata_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        check("bp_rd1_data", 64'({rdata_valid, rdata}), 64'({1'b1, 8'hBB}));
        step();
        rdata_ready = 1; rsp_ready = 1;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        check("bp_rsp", 64'({rsp_valid, rsp_status, rsp_count}), 64'({1'b1, 2'b00, 8'd2}));
        step();
        check("bp_nbytes", 64'(log_n - base), 64'd3);

        // ---- zero length command ----
        base = log_n;
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'h11; cmd_len = 0; rsp_ready = 0;
        step();
        cmd_valid = 0;
        check("len0_rsp", 64'({rsp_valid, rsp_status, rsp_count, cmd_ready, busy, eng_start}),
              64'({1'b1, 2'b11, 8'h00, 1'b0, 1'b1, 1'b0}));
        step();
        step();
        check("len0_rsp_held", 64'({rsp_valid, cmd_ready}), 64'({1'b1, 1'b0}));
        rsp_ready = 1;
        step();
        check("len0_back_idle", 64'({rsp_valid, cmd_ready, busy}), 64'({1'b0, 1'b1, 1'b0}));
        check("len0_no_bus", 64'(log_n - base), 64'd0);

        // ---- reset while a write data byte is in flight ----
        base = log_n; nack_abs = -1000;
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'h50; cmd_len = 2;
        wdata_valid = 1; wdata = 8'hA5; rsp_ready = 1;
        step();
        cmd_valid = 0;
        cyc = 0;
        while (!(log_n == base + 2 && eng_idle === 1'b0) && cyc < 200) begin @(negedge clk); cyc++; end
        check("rst_reached_data_wait", 64'(log_n - base), 64'd2);
        step();
        resetn = 0;
        @(negedge clk);
        check("rst_mid_outputs", 64'(out_bundle()), 64'(c_RESET_OUTS));
        wdata_valid = 0;
        repeat (6) step();
        resetn = 1;
        step();
        check("rst_release_outputs", 64'(out_bundle()), 64'(c_RESET_OUTS));
        step();

        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
